// File: rtl/sample_dma_writer_pkg.sv
// Shared types and defaults for the sample DMA writer.
// FSM state encoding and default bus widths used by the interface and RTL.
package sample_dma_writer_pkg;

  localparam int AW_DEFAULT = 24;
  localparam int DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_REQ   = 2'd2,
    ST_WAIT  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/sample_dma_writer_if.sv
// SDRAM initiator port: request (avalid/aready) plus completion pulse (bvalid).
// The master modport is the DMA side; the slave modport is the SDRAM controller side.
interface sample_dma_writer_if
  import sample_dma_writer_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) ();

  logic          avalid;
  logic          aready;
  logic          awe;
  logic [AW-1:0] aaddr;
  logic [DW-1:0] adata;
  logic          bvalid;

  modport master (
    output avalid,
    output awe,
    output aaddr,
    output adata,
    input  aready,
    input  bvalid
  );

  modport slave (
    input  avalid,
    input  awe,
    input  aaddr,
    input  adata,
    output aready,
    output bvalid
  );

endinterface

// File: rtl/sample_dma_writer_ring_ptr_inc.sv
// Circular-buffer pointer increment: ptr+1, wrapping from ring_limit back to ring_base.
// Purely combinational so it can be shared with a future SDRAM->USB reader.
module ring_ptr_inc #(
  parameter int AW = 24
) (
  input  logic [AW-1:0] ptr,
  input  logic [AW-1:0] ring_base,
  input  logic [AW-1:0] ring_limit,
  output logic [AW-1:0] nxt
);

  logic [AW-1:0] inc;

  always_comb begin
    inc = ptr + {{(AW-1){1'b0}}, 1'b1};
    nxt = (inc == ring_limit) ? ring_base : inc;
  end

endmodule

// File: rtl/sample_dma_writer.sv
// Drains sample_fifo and writes each sample word into an SDRAM ring buffer,
// one outstanding SDRAM write at a time.
module sample_dma_writer
  import sample_dma_writer_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [AW-1:0]       ring_base,
  input  logic [AW-1:0]       ring_limit,
  input  logic [AW-1:0]       rd_ptr,
  output logic [AW-1:0]       wr_ptr,
  input  logic                fifo_empty,
  output logic                fifo_rd,
  input  logic [DW-1:0]       fifo_data,
  sample_dma_writer_if.master sdram,
  output logic                ring_full,
  output logic                busy,
  output logic [31:0]         words_written
);

  dma_state_e    state, state_d;
  logic          enable_q;
  logic          en_rise;
  logic          go;
  logic          avalid_q;
  logic [AW-1:0] aaddr_q;
  logic [DW-1:0] adata_q;
  logic [AW-1:0] nxt;

  ring_ptr_inc #(.AW(AW)) u_ring_ptr_inc (
    .ptr        (wr_ptr),
    .ring_base  (ring_base),
    .ring_limit (ring_limit),
    .nxt        (nxt)
  );

  assign ring_full    = (nxt == rd_ptr);
  assign busy         = (state != ST_IDLE);
  assign en_rise      = enable && !enable_q;
  // Starting needs enable seen on two consecutive cycles: the rising-edge cycle
  // reloads wr_ptr, so ring_full is only trusted from the next cycle on. The
  // registered term also keeps fifo_rd low while reset is held.
  assign go           = enable && enable_q && !fifo_empty && !ring_full;

  assign sdram.avalid = avalid_q;
  assign sdram.awe    = avalid_q;
  assign sdram.aaddr  = aaddr_q;
  assign sdram.adata  = adata_q;

  always_comb begin
    state_d = state;
    fifo_rd = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (go) begin
          fifo_rd = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_REQ;
      ST_REQ: begin
        if (sdram.aready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sdram.bvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      enable_q      <= 1'b0;
      wr_ptr        <= '0;
      avalid_q      <= 1'b0;
      aaddr_q       <= '0;
      adata_q       <= '0;
      words_written <= '0;
    end else begin
      state    <= state_d;
      enable_q <= enable;
      unique case (state)
        ST_IDLE: begin
          if (en_rise) begin
            wr_ptr        <= ring_base;
            words_written <= '0;
          end
        end
        ST_FETCH: begin
          adata_q  <= fifo_data;
          aaddr_q  <= wr_ptr;
          avalid_q <= 1'b1;
        end
        ST_REQ: begin
          if (sdram.aready) avalid_q <= 1'b0;
        end
        ST_WAIT: begin
          if (sdram.bvalid) begin
            wr_ptr        <= nxt;
            words_written <= words_written + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
